// File: rtl/shift_counter_gen.sv
// shift_counter_gen: parametrised ring / Johnson shift counter.
// Produces a one-hot (ring) or twisted-ring (Johnson) sequence with a step
// index, a wrap pulse, and self-correction of illegal states with a sticky
// error flag. All outputs are registered.
module shift_counter_gen #(
  parameter int WIDTH    = 8,
  parameter int INIT_POS = WIDTH - 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init,
  input  logic                           en,
  input  logic                           dir,
  input  logic                           mode,
  output logic [WIDTH-1:0]               count,
  output logic [$clog2(2*WIDTH)-1:0]     pos,
  output logic                           wrap,
  output logic                           err
);

  localparam int PW = $clog2(2*WIDTH);

  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    POS_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]    POS_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    RING_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    JOHN_LAST = PW'(2*WIDTH - 1);

  // Ring seed is a single hot bit at INIT_POS; Johnson seed is all zeros.
  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    logic [WIDTH-1:0] s;
    s = ZERO;
    if (m == 1'b0) begin
      s[INIT_POS] = 1'b1;
    end else begin
      s = ZERO;
    end
    return s;
  endfunction

  // Ring legality: exactly one bit set.
  function automatic logic ring_legal(input logic [WIDTH-1:0] c);
    return (c != ZERO) && ((c & (c - ONE)) == ZERO);
  endfunction

  // Johnson legality: ones packed against the LSB or against the MSB.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] nc;
    nc = ~c;
    return ((c & (c + ONE)) == ZERO) || ((nc & (nc + ONE)) == ZERO);
  endfunction

  logic [WIDTH-1:0] count_r;
  logic [PW-1:0]    pos_r;
  logic             wrap_r;
  logic             err_r;
  logic             mode_q;

  logic             legal_s;
  logic [PW-1:0]    last_s;
  logic [WIDTH-1:0] step_count_s;
  logic [PW-1:0]    step_pos_s;
  logic             step_wrap_s;

  assign count = count_r;
  assign pos   = pos_r;
  assign wrap  = wrap_r;
  assign err   = err_r;

  // Decide whether the current state is a member of the active sequence.
  always_comb begin
    legal_s = 1'b0;
    if (mode_q == 1'b0) begin
      legal_s = ring_legal(count_r);
    end else begin
      legal_s = johnson_legal(count_r);
    end
  end

  // Compute the next count, step index and wrap for a legal enabled step.
  // The feedback bit is inverted in Johnson mode (xor with mode_q).
  always_comb begin
    step_count_s = count_r;
    step_pos_s   = pos_r;
    step_wrap_s  = 1'b0;
    last_s       = (mode_q == 1'b1) ? JOHN_LAST : RING_LAST;
    if (dir == 1'b0) begin
      step_count_s = {count_r[WIDTH-2:0], count_r[WIDTH-1] ^ mode_q};
      if (pos_r == last_s) begin
        step_pos_s  = POS_ZERO;
        step_wrap_s = 1'b1;
      end else begin
        step_pos_s  = pos_r + POS_ONE;
        step_wrap_s = 1'b0;
      end
    end else begin
      step_count_s = {count_r[0] ^ mode_q, count_r[WIDTH-1:1]};
      if (pos_r == POS_ZERO) begin
        step_pos_s  = last_s;
        step_wrap_s = 1'b1;
      end else begin
        step_pos_s  = pos_r - POS_ONE;
        step_wrap_s = 1'b0;
      end
    end
  end

  // State update: init has priority over en; illegal states are reseeded on
  // the next enabled step and flagged in the sticky error bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      count_r <= seed_of(1'b0);
      pos_r   <= POS_ZERO;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (init) begin
      mode_q  <= mode;
      count_r <= seed_of(mode);
      pos_r   <= POS_ZERO;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (en) begin
      if (legal_s) begin
        count_r <= step_count_s;
        pos_r   <= step_pos_s;
        wrap_r  <= step_wrap_s;
      end else begin
        count_r <= seed_of(mode_q);
        pos_r   <= POS_ZERO;
        wrap_r  <= 1'b0;
        err_r   <= 1'b1;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Self-checking bench for shift_counter_gen (WIDTH=8, INIT_POS=7).
// Expected values come from a step-index model: count is derived from the
// modelled position, not from shifting, and queued until the DUT responds.
module tb_shift_counter_gen;

  localparam int W  = 8;
  localparam int IP = 7;

  logic       clk = 1'b0;
  logic       rst_n, init, en, dir, mode;
  logic [7:0] count;
  logic [3:0] pos;
  logic       wrap, err;

  shift_counter_gen #(.WIDTH(W), .INIT_POS(IP)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .en(en), .dir(dir), .mode(mode),
    .count(count), .pos(pos), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic [3:0] p;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic mode_m = 1'b0;
  int   pos_m  = 0;
  logic err_m  = 1'b0;
  logic bad_m  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sequence value at step index p from the seed.
  function automatic logic [7:0] cnt_of(input logic m, input int p);
    logic [15:0] t;
    if (!m) begin
      t = 16'd1 << ((IP + p) % W);
    end else if (p <= W) begin
      t = (16'd1 << p) - 16'd1;
    end else begin
      t = ~((16'd1 << (p - W)) - 16'd1);
    end
    return t[7:0];
  endfunction

  task automatic compare_out(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check_val({tag, "_count"}, {24'd0, count}, {24'd0, x.c});
      check_val({tag, "_pos"},   {28'd0, pos},   {28'd0, x.p});
      check_val({tag, "_wrap"},  {31'd0, wrap},  {31'd0, x.w});
      check_val({tag, "_err"},   {31'd0, err},   {31'd0, x.e});
    end
  endtask

  // One clock of stimulus: drive at negedge, model, compare after posedge.
  task automatic drive(input string tag, input logic i, input logic e, input logic d, input logic m);
    exp_t x;
    int   per;
    logic w;
    @(negedge clk);
    init = i; en = e; dir = d; mode = m;
    w = 1'b0;
    if (i) begin
      mode_m = m; pos_m = 0; err_m = 1'b0; bad_m = 1'b0;
    end else if (e) begin
      if (bad_m) begin
        pos_m = 0; err_m = 1'b1; bad_m = 1'b0;
      end else begin
        per = mode_m ? 2*W : W;
        if (!d) begin
          if (pos_m == per - 1) begin pos_m = 0; w = 1'b1; end
          else pos_m++;
        end else begin
          if (pos_m == 0) begin pos_m = per - 1; w = 1'b1; end
          else pos_m--;
        end
      end
    end
    x.c = cnt_of(mode_m, pos_m);
    x.p = pos_m[3:0];
    x.w = w;
    x.e = err_m;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0;
    #12;
    check_val("rst_count", {24'd0, count}, 32'h80);
    check_val("rst_pos",   {28'd0, pos},   32'd0);
    check_val("rst_wrap",  {31'd0, wrap},  32'd0);
    check_val("rst_err",   {31'd0, err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ring toward MSB, one full period.
    for (int k = 0; k < 8; k++) drive("ring_up", 1'b0, 1'b1, 1'b0, 1'b0);
    // Ring toward LSB, one full period plus one.
    for (int k = 0; k < 9; k++) drive("ring_dn", 1'b0, 1'b1, 1'b1, 1'b0);
    // Direction changes mid-stream.
    drive("ring_mix", 1'b0, 1'b1, 1'b0, 1'b0);
    drive("ring_mix", 1'b0, 1'b1, 1'b1, 1'b0);
    drive("ring_mix", 1'b0, 1'b1, 1'b1, 1'b0);

    // Johnson, full 16-step period with a hold in the middle.
    drive("john_init", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) drive("john_up", 1'b0, 1'b1, 1'b0, 1'b0);
    drive("john_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    drive("john_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) drive("john_up", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive("john_dn", 1'b0, 1'b1, 1'b1, 1'b0);

    // Illegal state in ring mode: corrected on the next enabled step.
    drive("bad_init", 1'b1, 1'b0, 1'b0, 1'b0);
    drive("bad_pre", 1'b0, 1'b1, 1'b0, 1'b0);
    force dut.count_r = 8'h81;
    #1;
    release dut.count_r;
    bad_m = 1'b1;
    drive("bad_fix", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) drive("err_sticky", 1'b0, 1'b1, k[0], 1'b0);
    drive("err_clr", 1'b1, 1'b0, 1'b0, 1'b0);

    // init beats en in the same cycle.
    drive("init_en_j", 1'b1, 1'b1, 1'b0, 1'b1);
    drive("init_en_j_step", 1'b0, 1'b1, 1'b0, 1'b0);
    drive("init_en_r", 1'b1, 1'b1, 1'b1, 1'b0);

    // Async reset from Johnson at 0F, between clock edges.
    drive("ar_init", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) drive("ar_pre", 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("ar_pre_count", {24'd0, count}, 32'h0F);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_count", {24'd0, count}, 32'h80);
    check_val("ar_pos",   {28'd0, pos},   32'd0);
    check_val("ar_wrap",  {31'd0, wrap},  32'd0);
    check_val("ar_err",   {31'd0, err},   32'd0);
    check_val("ar_mode",  {31'd0, dut.mode_q}, 32'd0);
    mode_m = 1'b0; pos_m = 0; err_m = 1'b0; bad_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) drive("ar_resume", 1'b0, 1'b1, 1'b0, 1'b0);

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
